// File: rtl/data_mem_responder.sv
// Data-memory responder: inserts LATENCY wait states before each access completes with a one-cycle ready pulse.
// Optional misaligned-access detection is enabled by defining MISALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        count_q, count_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic              mis_q, mis_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              ready_q, ready_d;
  logic              err_q, err_d;

  logic [31:0]       mem [DEPTH];
  logic              req;
  logic              misaligned;
  logic              mem_we;
  logic              unused_addr_bits;

  assign req = read_en | write_en;
  // High address bits alias modulo DEPTH; the byte offset is only inspected when checking is on.
  assign unused_addr_bits = ^{address[31:ADDR_W+2], address[1:0]};

`ifdef MISALIGN_CHECK_EN
  assign misaligned = |address[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    mis_d      = mis_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          idx_d   = address[ADDR_W+1:2];
          wdata_d = data_in;
          is_wr_d = write_en;
          mis_d   = misaligned;
          count_d = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (count_q == 4'd0) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = mis_q;
          if (!is_wr_q) begin
            data_out_d = mis_q ? 32'd0 : mem[idx_q];
          end
        end else begin
          count_d = count_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      idx_q      <= '0;
      wdata_q    <= 32'd0;
      is_wr_q    <= 1'b0;
      mis_q      <= 1'b0;
      data_out_q <= 32'd0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      mis_q      <= mis_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  // Stores commit on the edge leaving RESP, so a reset on that edge still aborts them.
  assign mem_we = (state_q == RESP) && is_wr_q && !mis_q && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign stall    = ((state_q == IDLE) && req) || (state_q == WAIT);
  assign data_out = data_out_q;
  assign ready    = ready_q;
  assign err      = err_q;

endmodule
